// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur game: state encoding, height reference,
// obstacle-type constants and score width. Also used by the jump stage and renderer.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // Height reported by the jump stage when the dinosaur stands on the ground
  localparam logic [5:0] GROUND_HEIGHT = 6'd63;

  localparam logic OBST_TYPE0 = 1'b0;
  localparam logic OBST_TYPE1 = 1'b1;

  localparam int SCORE_W = 14;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

endpackage

// File: rtl/dino_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4), free-running every clock.
module dino_lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST_N,
  output logic [7:0] state
);

  // Shift left, feeding back the XOR of taps 8,6,5,4 into bit 0
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= SEED;
    end else begin
      state <= {state[6:0], state[7] ^ state[5] ^ state[4] ^ state[3]};
    end
  end

endmodule

// File: rtl/dino_game_ctrl.sv
// Game controller: idle/run/over state machine, one scrolling obstacle with
// pseudo-random type, collision detection against the dinosaur, and score.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int         SCREEN_W  = 160,
  parameter int         DINO_X    = 16,
  parameter int         DINO_W    = 8,
  parameter int         OBST_H0   = 10,
  parameter int         OBST_H1   = 18,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               tick,
  input  logic               button_start,
  input  logic [5:0]         dinosaur_height,
  output logic               game_status,
  output logic [7:0]         obstacle_x,
  output logic               obstacle_type,
  output logic [SCORE_W-1:0] score,
  output logic               crash
);

  localparam logic [7:0] SPAWN_X = 8'(SCREEN_W - 1);
  localparam logic [7:0] X_LO    = 8'(DINO_X);
  localparam logic [7:0] X_HI    = 8'(DINO_X + DINO_W - 1);
  localparam logic [5:0] H0      = 6'(OBST_H0);
  localparam logic [5:0] H1      = 6'(OBST_H1);

  state_t             state_q;
  state_t             state_d;
  logic               start_q;
  logic               start_rise;
  logic [7:0]         lfsr;
  logic               lfsr_unused;
  logic [5:0]         clearance;
  logic               hit;
  logic               status_d;
  logic               crash_d;
  logic [7:0]         x_d;
  logic               type_d;
  logic [SCORE_W-1:0] score_d;

  function automatic logic [SCORE_W-1:0] score_sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

  dino_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .state (lfsr)
  );

  // Only bit 0 picks the obstacle type; the rest of the state is not consumed here
  assign lfsr_unused = ^lfsr[7:1];

  // Remember the previous button level to detect a single press edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      start_q <= 1'b0;
    end else begin
      start_q <= button_start;
    end
  end

  assign start_rise = button_start & ~start_q;

  // Height above ground cannot underflow because the jump stage never exceeds 63
  assign clearance = GROUND_HEIGHT - dinosaur_height;
  assign hit = (obstacle_x >= X_LO) && (obstacle_x <= X_HI) &&
               (clearance < ((obstacle_type == OBST_TYPE1) ? H1 : H0));

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start edges (re)enter RUN, a ticked hit ends the run
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, OVER: if (start_rise) state_d = RUN;
      RUN:        if (tick && hit) state_d = OVER;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs; a hit freezes x and score
  always_comb begin
    status_d = (state_d == RUN);
    crash_d  = (state_q == RUN) && (state_d == OVER);
    x_d      = obstacle_x;
    type_d   = obstacle_type;
    score_d  = score;
    if ((state_q != RUN) && (state_d == RUN)) begin
      x_d     = SPAWN_X;
      type_d  = lfsr[0];
      score_d = '0;
    end else if ((state_q == RUN) && tick && !hit) begin
      if (obstacle_x == 8'd0) begin
        x_d     = SPAWN_X;
        type_d  = lfsr[0];
        score_d = score_sat_inc(score);
      end else begin
        x_d = obstacle_x - 8'd1;
      end
    end
  end

  // Output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      game_status   <= 1'b0;
      crash         <= 1'b0;
      obstacle_x    <= SPAWN_X;
      obstacle_type <= OBST_TYPE0;
      score         <= '0;
    end else begin
      game_status   <= status_d;
      crash         <= crash_d;
      obstacle_x    <= x_d;
      obstacle_type <= type_d;
      score         <= score_d;
    end
  end

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Scoreboard bench for dino_game_ctrl: expected outputs are queued when each
// cycle's stimulus is driven and compared after the following clock edge.
module tb_dino_game_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        tick;
  logic        button_start;
  logic [5:0]  dinosaur_height;
  logic        game_status;
  logic [7:0]  obstacle_x;
  logic        obstacle_type;
  logic [13:0] score;
  logic        crash;

  int checks = 0;
  int errors = 0;
  int crash_cnt = 0;

  int    sel_q[$];
  int    val_q[$];
  string tag_q[$];

  // Expected values for the outputs after the next clock edge
  int e_st, e_x, e_ty, e_sc, e_cr;

  logic [7:0] lfsr_m;

  dino_game_ctrl dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .tick            (tick),
    .button_start    (button_start),
    .dinosaur_height (dinosaur_height),
    .game_status     (game_status),
    .obstacle_x      (obstacle_x),
    .obstacle_type   (obstacle_type),
    .score           (score),
    .crash           (crash)
  );

  always #5 CLK = ~CLK;

  // Reference LFSR: x^8+x^6+x^5+x^4, seed A5, advancing every clock
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) lfsr_m <= 8'hA5;
    else        lfsr_m <= {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  always @(negedge CLK) begin
    if (crash === 1'b1) crash_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return {31'd0, game_status};
      1:       return {24'd0, obstacle_x};
      2:       return {31'd0, obstacle_type};
      3:       return {18'd0, score};
      default: return {31'd0, crash};
    endcase
  endfunction

  task automatic push(input int sel, input string tag, input int val);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
    val_q.push_back(val);
  endtask

  task automatic drain();
    while (sel_q.size() > 0) begin
      int    s;
      int    v;
      string t;
      s = sel_q.pop_front();
      v = val_q.pop_front();
      t = tag_q.pop_front();
      check(t, observe(s), v);
    end
  endtask

  // One clock: queue expectations, drive inputs, clock, then score
  task automatic step(input logic tk, input logic btn, input logic [5:0] h);
    push(0, "game_status", e_st);
    push(1, "obstacle_x", e_x);
    push(2, "obstacle_type", e_ty);
    push(3, "score", e_sc);
    push(4, "crash", e_cr);
    tick = tk;
    button_start = btn;
    dinosaur_height = h;
    @(posedge CLK);
    #1;
    drain();
  endtask

  // n ticks that must each move the obstacle one column left without a hit
  task automatic move(input int n, input logic [5:0] h);
    for (int i = 0; i < n; i++) begin
      e_x = e_x - 1;
      e_cr = 0;
      step(1'b1, 1'b0, h);
    end
  endtask

  // Idle (no tick) until the LFSR bit about to be sampled equals t, bounded
  task automatic wait_type(input logic t);
    int k;
    k = 0;
    e_cr = 0;
    while (lfsr_m[0] !== t && k < 20) begin
      step(1'b0, 1'b0, 6'd40);
      k++;
    end
    check("type_wait_bound", (k < 20) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Tick at x==0: respawn at column 159 with the requested type, score+1
  task automatic respawn(input logic t);
    wait_type(t);
    e_x = 159;
    e_ty = int'(t);
    e_sc = e_sc + 1;
    step(1'b1, 1'b0, 6'd40);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_status"}, {31'd0, game_status}, 0);
    check({pfx, "_x"}, {24'd0, obstacle_x}, 159);
    check({pfx, "_type"}, {31'd0, obstacle_type}, 0);
    check({pfx, "_score"}, {18'd0, score}, 0);
    check({pfx, "_crash"}, {31'd0, crash}, 0);
  endtask

  initial begin
    RST_N = 1'b0;
    tick = 1'b0;
    button_start = 1'b0;
    dinosaur_height = 6'd63;
    #12;
    check_reset_values("reset");

    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    e_st = 0; e_x = 159; e_ty = 0; e_sc = 0; e_cr = 0;

    // IDLE ignores ticks
    step(1'b0, 1'b0, 6'd63);
    step(1'b1, 1'b0, 6'd63);

    // Held start button: exactly one transition into RUN
    e_st = 1;
    e_ty = int'(lfsr_m[0]);
    step(1'b0, 1'b1, 6'd63);
    repeat (9) step(1'b0, 1'b1, 6'd63);
    step(1'b0, 1'b0, 6'd63);

    // Grounded dinosaur: 136 moves to x=23, with non-tick cycles holding
    for (int i = 1; i <= 136; i++) begin
      move(1, 6'd63);
      if (i % 32 == 0) step(1'b0, 1'b0, 6'd0);
    end
    // Tick 137 at x=23 hits: crash pulse, x and score held
    e_st = 0;
    e_cr = 1;
    step(1'b1, 1'b0, 6'd63);
    e_cr = 0;
    step(1'b1, 1'b0, 6'd63);
    step(1'b0, 1'b0, 6'd63);

    // Restart from OVER with a coincident tick: no move on that cycle
    e_st = 1; e_x = 159; e_sc = 0; e_ty = int'(lfsr_m[0]);
    step(1'b1, 1'b1, 6'd63);
    step(1'b0, 1'b0, 6'd40);

    // Clearance 23 clears both types: run to x=0 and respawn as type 0
    move(159, 6'd40);
    respawn(1'b0);

    // Type 0 with clearance 15 at x=20: no hit
    move(139, 6'd40);
    e_x = 19;
    step(1'b1, 1'b0, 6'd48);
    move(19, 6'd40);

    for (int r = 0; r < 3; r++) begin
      respawn(1'b0);
      move(159, 6'd40);
    end
    respawn(1'b1);

    // Type 1 with clearance 15 at x=20: hit, score 5 held
    move(139, 6'd40);
    e_st = 0;
    e_cr = 1;
    step(1'b1, 1'b0, 6'd48);
    e_cr = 0;
    repeat (3) step(1'b1, 1'b0, 6'd48);

    // Direct restart from OVER clears the score
    e_st = 1; e_x = 159; e_sc = 0; e_ty = int'(lfsr_m[0]);
    step(1'b1, 1'b1, 6'd63);
    step(1'b0, 1'b0, 6'd63);

    // Asynchronous reset mid-run at x=80
    move(79, 6'd40);
    #3;
    RST_N = 1'b0;
    #1;
    check_reset_values("midrun_reset");
    repeat (2) @(posedge CLK);
    #1;
    check_reset_values("held_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    e_st = 0; e_x = 159; e_ty = 0; e_sc = 0; e_cr = 0;
    step(1'b1, 1'b0, 6'd63);

    check("crash_pulses", crash_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dino_game_ctrl.md
Name: dino_game_ctrl

Overview:
- Downstream consumer of the jump stage's `dinosaur_height`.
- Produces the `game_status` the jump stage qualifies on.
- Owns the game state machine (idle/run/over) and a single scrolling obstacle with pseudo-random type.
- Also owns collision detection against the dinosaur and the pass-count score.
- Outputs feed the VGA renderer and the score display.

Parameters:
- SCREEN_W, 160, obstacle spawn column is SCREEN_W-1; legal range 32..256.
- DINO_X, 16, leftmost column of the dinosaur sprite.
- DINO_W, 8, dinosaur width in columns.
- OBST_H0, 10, clearance height of obstacle type 0.
- OBST_H1, 18, clearance height of obstacle type 1.
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- CLK, input, 1, system clock.
- RST_N, input, 1, asynchronous active-low reset.
- tick, input, 1, one-cycle game-step strobe from the frame divider.
- button_start, input, 1, level from the debounced start button.
- dinosaur_height, input, 6, jump stage output: 63 = grounded, smaller values = higher in the air.
- game_status, output, 1, 1 while in RUN.
- obstacle_x, output, 8, current obstacle column.
- obstacle_type, output, 1, selects OBST_H0 (0) or OBST_H1 (1).
- score, output, 14, obstacles cleared in the current run.
- crash, output, 1, one-cycle pulse on entry to OVER.

Behaviour:
- Reset (asynchronous, RST_N=0) sets:
  - state=IDLE, game_status=0, crash=0, score=0.
  - obstacle_x=SCREEN_W-1, obstacle_type=0.
  - lfsr=LFSR_SEED; start_q=0.
- All outputs are registered.
- Start edge:
  - start_q samples button_start every cycle.
  - start_rise = button_start & ~start_q.
  - Holding the button yields exactly one rise.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every cycle, in every state, independent of tick.
- Clearance = 63 - dinosaur_height, 6-bit unsigned, no overflow possible.
- hit (combinational) is true when all of:
  - DINO_X <= obstacle_x <= DINO_X+DINO_W-1.
  - clearance < (obstacle_type ? OBST_H1 : OBST_H0).
- State IDLE:
  - game_status=0; obstacle frozen.
  - start_rise -> RUN.
  - On entering RUN: score=0, obstacle_x=SCREEN_W-1, obstacle_type=lfsr[0].
- State RUN:
  - game_status=1 from the cycle after the start_rise cycle.
  - Only cycles with tick=1 act; other cycles hold everything.
  - tick & hit (evaluated on the pre-move obstacle_x) -> OVER next cycle.
    - crash=1 for exactly that one cycle.
    - obstacle_x and score do not change on that tick.
  - tick & ~hit & obstacle_x==0 -> respawn.
    - obstacle_x=SCREEN_W-1, obstacle_type=lfsr[0].
    - score+1, saturating at 16383.
  - tick & ~hit otherwise -> obstacle_x-1.
  - Priority: hit > respawn > move.
  - start_rise in RUN is ignored.
- State OVER:
  - game_status=0; obstacle_x, obstacle_type and score held for display.
  - start_rise -> RUN, same initialisation as IDLE->RUN (direct restart).
- A tick coincident with start_rise in IDLE/OVER is consumed by the transition; no move occurs on that cycle.
- RST_N asserted mid-run returns to IDLE immediately with reset values; no crash pulse.
- dinosaur_height is sampled only on tick cycles in RUN; its value elsewhere is don't-care.

Decomposition:
- Shared package dino_pkg holds:
  - state enum {IDLE, RUN, OVER}.
  - GROUND_HEIGHT=6'd63.
  - Obstacle-type constants.
  - Score width 14.
  - The jump stage and renderer also use this package.
- One sub-module, dino_lfsr8 (CLK, RST_N, seed parameter, 8-bit state out), reused later for cloud/cactus spacing.

Test Plan:
- Reset with RST_N=0 → game_status=0, obstacle_x=159, score=0, crash=0; hold button_start high 10 cycles after release of reset → exactly one IDLE→RUN, game_status=1 on the cycle after the first rising edge.
- RUN, height=63, type 0, 137 ticks → x goes 159→23 after 136 ticks; tick 137 flags hit, crash pulses once, game_status=0 next cycle, obstacle_x stays 23, score=0.
- RUN, height=40 (clearance 23 > 18) for 160 ticks → no crash; at x=0 the tick respawns x=159 and score=1; type equals lfsr[0] at that cycle.
- Type-1 obstacle, height=48 (clearance 15 < 18) at x=20 → crash; same with type 0 (15 ≥ 10) → no crash, x=19.
- OVER with score=5, press start → RUN, score=0, x=159 next cycle; ticks asserted in the restart cycle cause no move.
- Drop RST_N while x=80 in RUN, no tick alignment → immediate IDLE, x=159, score=0, crash never asserted.
